// File: rtl/slave_port_controller_if.sv
// Boundary bundle of one slave port controller.
//   grant/m_req/m_cmd/m_addr/m_wdata : arbiter grant and packed master requests (master k = slice k)
//   m_ack/m_resp/m_rdata             : per-master acknowledge/response pulses, shared read data
//   s_req/s_cmd/s_addr/s_wdata       : request towards the slave
//   s_ack/s_resp/s_rdata             : slave responses
//   arb_release/grant_err/timeout    : status pulses
// Modport slave is the controller's view; modport master is the surrounding fabric's view.
interface slave_port_controller_if #(
  parameter int QTY_OF_MASTERS = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
);
  logic [QTY_OF_MASTERS-1:0]            grant;
  logic [QTY_OF_MASTERS-1:0]            m_req;
  logic [QTY_OF_MASTERS-1:0]            m_cmd;
  logic [QTY_OF_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [QTY_OF_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [QTY_OF_MASTERS-1:0]            m_ack;
  logic [QTY_OF_MASTERS-1:0]            m_resp;
  logic [DATA_WIDTH-1:0]                m_rdata;
  logic                                 s_req;
  logic                                 s_cmd;
  logic [ADDR_WIDTH-1:0]                s_addr;
  logic [DATA_WIDTH-1:0]                s_wdata;
  logic                                 s_ack;
  logic                                 s_resp;
  logic [DATA_WIDTH-1:0]                s_rdata;
  logic                                 arb_release;
  logic                                 grant_err;
  logic                                 timeout;

  modport slave (
    input  grant, m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp, m_rdata, s_req, s_cmd, s_addr, s_wdata,
           arb_release, grant_err, timeout
  );

  modport master (
    output grant, m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp, m_rdata, s_req, s_cmd, s_addr, s_wdata,
           arb_release, grant_err, timeout
  );
endinterface

// File: rtl/slave_port_controller.sv
// Slave port controller: forwards the granted master's request to the slave,
// routes ack/response pulses back to that master and releases the arbiter when
// the transaction ends (completion or wait timeout). All outputs are registered.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave_port_controller_if.slave (request/response bundle, see interface)
module slave_port_controller #(
  parameter int QTY_OF_MASTERS = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT        = 16
) (
  input logic                   clk,
  input logic                   rst,
  slave_port_controller_if.slave bus
);
  localparam int IDX_W = (QTY_OF_MASTERS > 1) ? $clog2(QTY_OF_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [QTY_OF_MASTERS-1:0] GNT_ONE  = QTY_OF_MASTERS'(1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        s_req_q, s_req_d;
  logic                        s_cmd_q, s_cmd_d;
  logic [ADDR_WIDTH-1:0]       s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]       s_wdata_q, s_wdata_d;
  logic [QTY_OF_MASTERS-1:0]   m_ack_q, m_ack_d;
  logic [QTY_OF_MASTERS-1:0]   m_resp_q, m_resp_d;
  logic [DATA_WIDTH-1:0]       m_rdata_q, m_rdata_d;
  logic                        arb_release_q, arb_release_d;
  logic                        grant_err_q, grant_err_d;
  logic                        timeout_q, timeout_d;

  // Decoded grant and the granted master's request fields
  logic                        gnt_multi, gnt_onehot;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        sel_req, sel_cmd;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic [DATA_WIDTH-1:0]       sel_wdata;
  logic [QTY_OF_MASTERS-1:0]   idx_onehot;

  // x & (x-1) clears the lowest set bit; anything left means more than one grant.
  assign gnt_multi  = |(bus.grant & (bus.grant - GNT_ONE));
  assign gnt_onehot = (|bus.grant) && !gnt_multi;

  always_comb begin
    gnt_idx   = '0;
    sel_req   = 1'b0;
    sel_cmd   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < QTY_OF_MASTERS; i++) begin
      if (bus.grant[i]) begin
        gnt_idx   = IDX_W'(i);
        sel_req   = bus.m_req[i];
        sel_cmd   = bus.m_cmd[i];
        sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    idx_onehot = '0;
    for (int unsigned i = 0; i < QTY_OF_MASTERS; i++) begin
      idx_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    s_req_d       = s_req_q;
    s_cmd_d       = s_cmd_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    m_rdata_d     = m_rdata_q;
    m_ack_d       = '0;
    m_resp_d      = '0;
    arb_release_d = 1'b0;
    grant_err_d   = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_multi) begin
          grant_err_d = 1'b1;
        end else if (gnt_onehot && sel_req) begin
          idx_d     = gnt_idx;
          s_cmd_d   = sel_cmd;
          s_addr_d  = sel_addr;
          s_wdata_d = sel_wdata;
          s_req_d   = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // s_ack takes priority over both s_resp and an expiring counter.
        if (bus.s_ack) begin
          s_req_d = 1'b0;
          m_ack_d = idx_onehot;
          cnt_d   = '0;
          if (s_cmd_q) begin
            arb_release_d = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          s_req_d       = 1'b0;
          timeout_d     = 1'b1;
          arb_release_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_RESP: begin
        if (bus.s_resp) begin
          m_rdata_d     = bus.s_rdata;
          m_resp_d      = idx_onehot;
          arb_release_d = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d     = 1'b1;
          arb_release_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      s_req_q       <= 1'b0;
      s_cmd_q       <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      m_ack_q       <= '0;
      m_resp_q      <= '0;
      m_rdata_q     <= '0;
      arb_release_q <= 1'b0;
      grant_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      s_req_q       <= s_req_d;
      s_cmd_q       <= s_cmd_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      m_ack_q       <= m_ack_d;
      m_resp_q      <= m_resp_d;
      m_rdata_q     <= m_rdata_d;
      arb_release_q <= arb_release_d;
      grant_err_q   <= grant_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.s_req       = s_req_q;
  assign bus.s_cmd       = s_cmd_q;
  assign bus.s_addr      = s_addr_q;
  assign bus.s_wdata     = s_wdata_q;
  assign bus.m_ack       = m_ack_q;
  assign bus.m_resp      = m_resp_q;
  assign bus.m_rdata     = m_rdata_q;
  assign bus.arb_release = arb_release_q;
  assign bus.grant_err   = grant_err_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: doc/slave_port_controller.md
SLAVE_PORT_CONTROLLER -- requirements
Module: slave_port_controller

Interface
REQ-001 Parameter QTY_OF_MASTERS, default 4, SHALL set the number of master ports feeding this slave.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-004 Parameter TIMEOUT, default 16, SHALL set the maximum number of wait cycles per handshake phase.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be rising-edge triggered.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port grant, input, QTY_OF_MASTERS: one-hot grant from this slave's round-robin arbiter.
REQ-008 Port m_req, input, QTY_OF_MASTERS: request bit of each master.
REQ-009 Port m_cmd, input, QTY_OF_MASTERS: per-master command, 1 = write, 0 = read.
REQ-010 Port m_addr, input, QTY_OF_MASTERS*ADDR_WIDTH: packed master addresses; master k occupies slice k.
REQ-011 Port m_wdata, input, QTY_OF_MASTERS*DATA_WIDTH: packed master write data; master k occupies slice k.
REQ-012 Port m_ack, output, QTY_OF_MASTERS: per-master acknowledge pulse.
REQ-013 Port m_resp, output, QTY_OF_MASTERS: per-master read-response pulse.
REQ-014 Port m_rdata, output, DATA_WIDTH: read data, shared by all masters.
REQ-015 Ports s_req, s_cmd, s_addr, s_wdata, outputs, widths 1/1/ADDR_WIDTH/DATA_WIDTH: request to the slave.
REQ-016 Ports s_ack, s_resp, inputs, 1 each; s_rdata, input, DATA_WIDTH: responses from the slave.
REQ-017 Port arb_release, output, 1: one-cycle pulse telling the arbiter that the current transaction has ended.
REQ-018 Port grant_err, output, 1: one-cycle pulse flagging a non-one-hot grant.
REQ-019 Port timeout, output, 1: one-cycle pulse flagging an aborted transaction.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The FSM SHALL have exactly three states: IDLE, WAIT_ACK, WAIT_RESP.
REQ-022 IDLE, grant one-hot at index k and m_req[k]=1: SHALL latch k, m_cmd[k], addr slice k and wdata slice k, assert s_req next cycle, and go to WAIT_ACK.
REQ-023 IDLE, grant one-hot and m_req[k]=0, or grant=0: SHALL stay in IDLE with no outputs changed.
REQ-024 IDLE, grant with more than one bit set: SHALL pulse grant_err for one cycle, start no transaction, and stay in IDLE.
REQ-025 While the FSM is not in IDLE, s_cmd, s_addr and s_wdata SHALL hold the latched values, ignoring changes on grant, m_req and m_* inputs.
REQ-026 WAIT_ACK, s_ack sampled 1: s_req SHALL drop next cycle; m_ack[k] SHALL pulse next cycle for exactly one cycle.
REQ-027 After REQ-026 on a write: SHALL pulse arb_release together with m_ack[k] and return to IDLE.
REQ-028 After REQ-026 on a read: SHALL go to WAIT_RESP.
REQ-029 WAIT_RESP, s_resp sampled 1: m_rdata SHALL be loaded with s_rdata next cycle; m_resp[k] and arb_release SHALL pulse one cycle; FSM SHALL return to IDLE.
REQ-030 m_rdata SHALL hold its value until the next read capture.
REQ-031 s_resp in WAIT_ACK and s_ack in WAIT_RESP SHALL be ignored; s_ack and s_resp both high in WAIT_ACK SHALL be treated as s_ack only.
REQ-032 A wait counter SHALL clear on entry to WAIT_ACK and WAIT_RESP and increment each cycle spent in that state.
REQ-033 When the wait counter reaches TIMEOUT-1 without the awaited input: next cycle s_req=0, timeout and arb_release SHALL pulse one cycle, m_ack and m_resp SHALL stay 0, and the FSM SHALL return to IDLE.
REQ-034 The awaited input sampled on the same cycle the count reaches TIMEOUT-1 SHALL win over the timeout.
REQ-035 A new transaction SHALL start no earlier than the first IDLE cycle after return to IDLE, giving at least one idle cycle between transactions.

Reset
REQ-036 rst=1 at a clock edge SHALL force: IDLE, wait counter=0, latched index=0, s_req=0, s_cmd=0, s_addr=0, s_wdata=0, m_ack=0, m_resp=0, m_rdata=0, arb_release=0, grant_err=0, timeout=0.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no m_ack, m_resp or arb_release pulse.

Verification
REQ-038 Write: grant=0010, m_req[1]=1, m_cmd[1]=1, addr1=0x4000_0010, wdata1=0xDEAD_BEEF; s_ack after 3 cycles -> s_* carry those values; m_ack=0010 and arb_release pulse one cycle; no m_resp.
REQ-039 Read: grant=1000, master 3 read; s_ack, then s_resp with s_rdata=0x1234_5678 -> m_ack=1000 pulse, then m_resp=1000 pulse with m_rdata=0x1234_5678 held afterwards.
REQ-040 grant=0110 in IDLE -> grant_err pulses once, s_req stays 0; grant=0100 with m_req[2]=0 -> no activity.
REQ-041 TIMEOUT=16 and s_ack never asserted -> s_req held 16 cycles then dropped; timeout and arb_release pulse; m_ack stays 0.
REQ-042 rst asserted in WAIT_RESP -> all outputs 0 next cycle, no m_resp; transaction after reset completes normally.
REQ-043 grant switched from 0001 to 0100 during WAIT_ACK -> s_addr unchanged; ack routed to m_ack[0] only.
